// File: rtl/wb_uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_uart_pkg;

  // Start bit + 8 data bits + stop bit.
  localparam int FRAME_BAUDS = 10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef logic [7:0] uart_byte_t;

  // Clock cycles the transmitter spends in START..STOP for one byte.
  function automatic int frame_ticks(input int tpb);
    return FRAME_BAUDS * tpb;
  endfunction

  // Frame counter width; kept at least 1 bit so an unset baud divisor still elaborates.
  function automatic int cnt_width(input int tpb);
    int ft;
    ft = FRAME_BAUDS * tpb;
    return (ft > 0) ? $clog2(ft + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_uart_tx_arb_rr_arbiter.sv
// Combinational round-robin pick: first requester above i_last, with wrap-around.
// Latency: 0 cycles (pure combinational; caller registers the result).
// Backpressure: none; o_vld low when no request bit is set.
//
// Ports:
//   i_req   request vector, one bit per requester
//   i_last  index of the previous winner (lowest priority this round)
//   o_gnt   one-hot grant
//   o_idx   binary index of the grant
//   o_vld   at least one request present
module rr_arbiter
  import wb_uart_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [NREQ-1:0]  o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_vld
);

  always_comb begin
    int                 pos;
    logic [IDX_W-1:0]   sel;
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    pos   = 0;
    sel   = '0;
    // Walk NREQ slots starting just above i_last; i_last itself is checked last.
    for (int k = 1; k <= NREQ; k++) begin
      pos = int'(i_last) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      sel = IDX_W'(pos);
      if (!o_vld && i_req[sel]) begin
        o_vld      = 1'b1;
        o_gnt[sel] = 1'b1;
        o_idx      = sel;
      end
    end
  end

endmodule

// File: rtl/wb_uart_tx_arb.sv
// Shares one wb_uart_tx between NREQ byte producers, round-robin per byte.
// Latency: request seen in IDLE -> tx_stb_o/req_ack_o one cycle later; one byte per 10*TICKS_PER_BAUD+1 cycles.
// Backpressure: requesters hold req_stb_i/data until their ack pulse; losers simply keep waiting.
//
// Ports:
//   wb_clk_i, wb_rst_ni   clock, asynchronous active-low reset
//   req_stb_i / req_dat_i per-requester valid and byte (requester i on bits [8i+7:8i])
//   req_lock_i            per-requester bus lock (only with WB_UART_TX_ARB_LOCK_EN defined)
//   req_ack_o             one-cycle one-hot accept pulse
//   tx_stb_o / tx_dat_o   strobe and byte to the transmitter's wb_stb_i / wb_dat_i
//   busy_o                a frame is in flight
// Optional feature macro: WB_UART_TX_ARB_LOCK_EN (the holder of a lock is re-granted
// while it keeps requesting, so multi-byte messages stay contiguous).
module wb_uart_tx_arb
  import wb_uart_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int TICKS_PER_BAUD = 0
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic [NREQ-1:0]     req_stb_i,
  input  logic [8*NREQ-1:0]   req_dat_i,
`ifdef WB_UART_TX_ARB_LOCK_EN
  input  logic [NREQ-1:0]     req_lock_i,
`endif
  output logic [NREQ-1:0]     req_ack_o,
  output logic                tx_stb_o,
  output uart_byte_t          tx_dat_o,
  output logic                busy_o
);

  localparam int IDX_W       = $clog2(NREQ);
  localparam int FRAME_TICKS = frame_ticks(TICKS_PER_BAUD);
  localparam int CNT_W       = cnt_width(TICKS_PER_BAUD);

  arb_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [IDX_W-1:0] r_last,  w_last_nxt;
  logic             r_stb,   w_stb_nxt;
  logic [NREQ-1:0]  r_ack,   w_ack_nxt;
  uart_byte_t       r_dat,   w_dat_nxt;
  logic             r_busy,  w_busy_nxt;

  uart_byte_t       w_req_byte [NREQ];
  logic [NREQ-1:0]  w_arb_gnt;
  logic [IDX_W-1:0] w_arb_idx;
  logic             w_arb_vld;
  logic             w_lock_hold;
  logic [NREQ-1:0]  w_win_gnt;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_win_vld;

  for (genvar g = 0; g < NREQ; g++) begin : g_req_byte
    assign w_req_byte[g] = req_dat_i[8*g +: 8];
  end

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .i_req  (req_stb_i),
    .i_last (r_last),
    .o_gnt  (w_arb_gnt),
    .o_idx  (w_arb_idx),
    .o_vld  (w_arb_vld)
  );

`ifdef WB_UART_TX_ARB_LOCK_EN
  // Lock only holds while its owner is still requesting; otherwise rotation resumes.
  assign w_lock_hold = req_lock_i[r_last] & req_stb_i[r_last];
`else
  assign w_lock_hold = 1'b0;
`endif

  assign w_win_vld = w_lock_hold | w_arb_vld;
  assign w_win_idx = w_lock_hold ? r_last : w_arb_idx;
  assign w_win_gnt = w_lock_hold ? (NREQ'(1) << r_last) : w_arb_gnt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_stb_nxt   = 1'b0;
    w_ack_nxt   = '0;
    w_dat_nxt   = r_dat;
    w_busy_nxt  = r_busy;
    unique case (r_state)
      IDLE: begin
        if (w_win_vld) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = CNT_W'(FRAME_TICKS);
          w_last_nxt  = w_win_idx;
          w_stb_nxt   = 1'b1;
          w_ack_nxt   = w_win_gnt;
          w_dat_nxt   = w_req_byte[w_win_idx];
          w_busy_nxt  = 1'b1;
        end else begin
          w_busy_nxt  = 1'b0;
        end
      end
      BUSY: begin
        // Leaving at cnt==1 lands the next IDLE edge exactly when the
        // transmitter is back in idle. The <= also covers an unset divisor.
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
          w_busy_nxt  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= IDX_W'(NREQ - 1);
      r_stb   <= 1'b0;
      r_ack   <= '0;
      r_dat   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_stb   <= w_stb_nxt;
      r_ack   <= w_ack_nxt;
      r_dat   <= w_dat_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign tx_stb_o  = r_stb;
  assign req_ack_o = r_ack;
  assign tx_dat_o  = r_dat;
  assign busy_o    = r_busy;

endmodule

// File: doc/wb_uart_tx_arb.md
# wb_uart_tx_arb

Round-robin arbiter and sequencer that shares a single `wb_uart_tx` transmitter between `NREQ` byte requesters. The transmitter has no ready/busy output, so this block tracks its frame time by counting clock ticks. It issues a one-cycle strobe only when the transmitter is guaranteed back in its idle state. It sits between on-chip byte producers (debug console, status reporter, etc.) and the transmitter's `wb_stb_i`/`wb_dat_i`.

## Interface
- `NREQ`, default 4: number of requesters, legal range 2..8.
- `TICKS_PER_BAUD`, default 0: clock cycles per UART bit. Must be set ≥1 and equal to the value given to the transmitter.
- `wb_clk_i`  in  1  single clock.
- `wb_rst_ni`  in  1  reset, asynchronous, active-low.
- `req_stb_i`  in  NREQ  request valid, one bit per requester.
- `req_dat_i`  in  8*NREQ  byte per requester; requester i uses bits [8i+7:8i].
- `req_ack_o`  out  NREQ  one-cycle accept pulse, one-hot.
- `tx_stb_o`  out  1  strobe to transmitter `wb_stb_i`.
- `tx_dat_o`  out  8  byte to transmitter `wb_dat_i`.
- `busy_o`  out  1  frame in flight (state BUSY).
- `req_lock_i`  in  NREQ  bus lock; present only with `WB_UART_TX_ARB_LOCK_EN`.

## Operation
- Reset values: `tx_stb_o`=0, `tx_dat_o`=0, `req_ack_o`=0, `busy_o`=0, state=IDLE, `cnt`=0, round-robin pointer `last`=NREQ-1.
- All outputs are registered.
- States:
  - IDLE: at an edge with any `req_stb_i` bit high, pick a winner w by searching upward from `last+1` with wrap-around. The same edge sets `tx_stb_o`=1, `req_ack_o[w]`=1, `tx_dat_o`=`req_dat_i[w]`, `last`=w, `cnt`=10*TICKS_PER_BAUD, state=BUSY.
  - BUSY: `tx_stb_o` and `req_ack_o` are forced to 0 after one cycle. `cnt` decrements by 1 on every edge; at `cnt`==1 the next state is IDLE and `cnt` becomes 0.
- `cnt` width is $clog2(10*TICKS_PER_BAUD+1). The count never wraps or underflows.
- Requester rule:
  - Hold `req_stb_i` and data stable until `req_ack_o` is sampled high.
  - If `req_stb_i` is still high on the edge after the ack, that is a new request.
  - Dropping `req_stb_i` before the ack withdraws the request without error.
- Simultaneous requests: exactly one ack per frame. Losers keep waiting, and the grant rotates, so there is no starvation.
- Reset mid-frame: the block returns to IDLE immediately. The integrator drives the transmitter reset from `!wb_rst_ni`, so both blocks abort together.
- `tx_dat_o` holds its last value while in BUSY and IDLE.

## Timing
- Request visible in cycle c (IDLE) → `tx_stb_o`/`req_ack_o` high in cycle c+1, for exactly one cycle.
- Strobe pulses are at least 10*TICKS_PER_BAUD+1 cycles apart. The transmitter occupies START..STOP for 10*TICKS_PER_BAUD cycles after sampling the strobe, so the next strobe is sampled at the first edge where it is idle.
- Back-to-back throughput: one byte per 10*TICKS_PER_BAUD+1 cycles.
- `busy_o` is high from cycle c+1 through the last BUSY cycle.

## Configuration
- `WB_UART_TX_ARB_LOCK_EN` defined:
  - `req_lock_i` port exists.
  - In IDLE, if `req_lock_i[last]` and `req_stb_i[last]` are both high, `last` is granted again regardless of rotation. This keeps a multi-byte message contiguous.
  - If `req_lock_i[last]` is high but `req_stb_i[last]` is low, the lock is released and normal rotation applies.
- Not defined: the port is absent and arbitration is pure round-robin per byte.

## Structure
- Shared package `wb_uart_pkg`:
  - `FRAME_BAUDS`=10.
  - State enum `{IDLE, BUSY}`.
  - `uart_byte_t` (8-bit).
- Sub-module `rr_arbiter` (NREQ-wide): combinational pick of the next winner given `req` and `last`. It returns a one-hot grant and its index. The sequencer registers the result.

## Test plan
- Use TICKS_PER_BAUD=2 and NREQ=4, so the frame period is 21 cycles.
1. Single request: `req_stb_i`=0001, `req_dat_i`[7:0]=0x55 → `tx_stb_o`=1 and `req_ack_o`=0001 one cycle later, `tx_dat_o`=0x55. `busy_o` stays high for 20 cycles. The transmitter's line shows start bit, 0x55 LSB first, then stop bit.
2. All four requesting continuously with bytes 0xA0..0xA3 → ack order 0,1,2,3,0. Consecutive strobes exactly 21 cycles apart. No dropped or duplicated byte on `uart_tx`.
3. Reset mid-frame: assert `wb_rst_ni`=0 eight cycles into a frame → all outputs 0 without waiting for a clock edge. After release, a request on requester 2 is granted first (`last`=3 at reset).
4. Withdraw: requester 1 raises and drops `req_stb_i` while another requester's frame is in BUSY → requester 1 never receives an ack. The next IDLE with no requests stays idle.
5. Lock (`WB_UART_TX_ARB_LOCK_EN`): requester 2 sends 3 bytes with `req_lock_i[2]`=1 while requester 0 also requests → acks 2,2,2, then 0 after requester 2 drops its lock.
6. Boundary: a request arrives exactly at the IDLE edge after `cnt` reaches 0 → strobe is issued with no extra idle cycle. The period is 21 cycles, not 22.
